// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with guard time between slots,
// double-buffered display data committed only on frame boundaries, and leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_en,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        pending,
  output logic        frame_tick
);

  localparam int MAX_CYC = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

  typedef enum logic {ST_ON, ST_GUARD} state_e;

  state_e      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [15:0] sh_val_q, sh_val_d;
  logic [3:0]  sh_dp_q, sh_dp_d;
  logic        sh_blz_q, sh_blz_d;
  logic        pend_q, pend_d;

  logic [15:0] act_val_q, act_val_d;
  logic [3:0]  act_dp_q, act_dp_d;
  logic        act_blz_q, act_blz_d;

  logic [3:0]  bcd_q, bcd_d;
  logic [3:0]  an_q, an_d;
  logic        dp_n_q, dp_n_d;
  logic        tick_q, tick_d;

  logic        last;
  logic        boundary;
  logic [3:0]  blank;
  logic [3:0]  digit;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    sh_blz_d  = sh_blz_q;
    pend_d    = pend_q;
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    act_blz_d = act_blz_q;
    bcd_d     = bcd_q;
    an_d      = 4'b1111;
    dp_n_d    = dp_n_q;
    boundary  = 1'b0;
    blank     = 4'b0000;
    digit     = 4'h0;

    last = (state_q == ST_ON) ? (cnt_q == ON_LAST) : (cnt_q == GUARD_LAST);
    if (last) begin
      cnt_d = '0;
      if (state_q == ST_ON) begin
        state_d = ST_GUARD;
      end else begin
        state_d  = ST_ON;
        slot_d   = slot_q + 2'd1;
        boundary = (slot_q == 2'd3);
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Commit uses the shadow as held before this edge; a coincident load refills it.
    if (boundary && pend_q) begin
      act_val_d = sh_val_q;
      act_dp_d  = sh_dp_q;
      act_blz_d = sh_blz_q;
      pend_d    = 1'b0;
    end
    if (load) begin
      sh_val_d = value;
      sh_dp_d  = dp_en;
      sh_blz_d = blank_lz;
      pend_d   = 1'b1;
    end

    blank[3] = act_blz_d && (act_val_d[15:12] == 4'h0);
    blank[2] = blank[3]  && (act_val_d[11:8]  == 4'h0);
    blank[1] = blank[2]  && (act_val_d[7:4]   == 4'h0);
    blank[0] = 1'b0;

    case (slot_d)
      2'd0:    digit = act_val_d[3:0];
      2'd1:    digit = act_val_d[7:4];
      2'd2:    digit = act_val_d[11:8];
      default: digit = act_val_d[15:12];
    endcase

    // Outputs are registered from next-state so they line up with the state they describe.
    if (state_d == ST_ON) begin
      bcd_d = digit;
      if (blank[slot_d]) begin
        an_d   = 4'b1111;
        dp_n_d = 1'b1;
      end else begin
        an_d   = ~(4'b0001 << slot_d);
        dp_n_d = ~act_dp_d[slot_d];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_GUARD;
      slot_q    <= 2'd3;
      cnt_q     <= '0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      sh_blz_q  <= 1'b0;
      pend_q    <= 1'b0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_blz_q <= 1'b0;
      bcd_q     <= 4'h0;
      an_q      <= 4'b1111;
      dp_n_q    <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      sh_blz_q  <= sh_blz_d;
      pend_q    <= pend_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      act_blz_q <= act_blz_d;
      bcd_q     <= bcd_d;
      an_q      <= an_d;
      dp_n_q    <= dp_n_d;
      tick_q    <= boundary;
    end
  end

  assign bcd        = bcd_q;
  assign an         = an_q;
  assign dp_n       = dp_n_q;
  assign pending    = pend_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with REFRESH_DIV=4, GUARD_CYC=1 (20-cycle frame).
module tb_seven_seg_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        dp_n;
  logic        pending;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  seven_seg_scan_ctrl #(.REFRESH_DIV(4), .GUARD_CYC(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .dp_en      (dp_en),
    .blank_lz   (blank_lz),
    .bcd        (bcd),
    .an         (an),
    .dp_n       (dp_n),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge following rising edge number t since reset release.
  task automatic to_edge(input int t);
    while (e < t) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic blz);
    load     = 1'b1;
    value    = v;
    dp_en    = dp;
    blank_lz = blz;
    to_edge(e + 1);
    load     = 1'b0;
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] exp_an, input logic [3:0] exp_bcd,
                          input logic exp_dp_n);
    chk({tag, "_an"}, {12'h0, an}, {12'h0, exp_an});
    chk({tag, "_bcd"}, {12'h0, bcd}, {12'h0, exp_bcd});
    chk({tag, "_dpn"}, {15'h0, dp_n}, {15'h0, exp_dp_n});
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    dp_en    = 4'h0;
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an", {12'h0, an}, 16'h000f);
    chk("rst_bcd", {12'h0, bcd}, 16'h0);
    chk("rst_dpn", {15'h0, dp_n}, 16'h1);
    chk("rst_pend", {15'h0, pending}, 16'h0);
    chk("rst_tick", {15'h0, frame_tick}, 16'h0);

    reset = 1'b0;
    e = 0;
    chk("rel_an", {12'h0, an}, 16'h000f);
    to_edge(1);
    chk_slot("f0_s0", 4'b1110, 4'h0, 1'b1);
    chk("f0_tick", {15'h0, frame_tick}, 16'h1);
    to_edge(2);
    chk("f0_tick_low", {15'h0, frame_tick}, 16'h0);
    to_edge(4);
    chk("f0_s0_end", {12'h0, an}, 16'h000e);
    to_edge(5);
    chk("f0_g0", {12'h0, an}, 16'h000f);
    to_edge(6);
    chk_slot("f0_s1", 4'b1101, 4'h0, 1'b1);
    to_edge(20);
    chk("f1_pre_tick", {15'h0, frame_tick}, 16'h0);
    to_edge(21);
    chk("f1_tick", {15'h0, frame_tick}, 16'h1);

    to_edge(22);
    do_load(16'h1234, 4'b0100, 1'b0);
    chk("l1234_pend", {15'h0, pending}, 16'h1);
    chk("l1234_nocommit", {12'h0, bcd}, 16'h0);
    to_edge(40);
    chk("l1234_pend_hold", {15'h0, pending}, 16'h1);
    to_edge(41);
    chk("l1234_pend_clr", {15'h0, pending}, 16'h0);
    chk_slot("h1234_s0", 4'b1110, 4'h4, 1'b1);

    do_load(16'h0050, 4'b0000, 1'b1);
    to_edge(46);
    chk_slot("h1234_s1", 4'b1101, 4'h3, 1'b1);
    to_edge(51);
    chk_slot("h1234_s2", 4'b1011, 4'h2, 1'b0);
    to_edge(55);
    chk_slot("h1234_g2", 4'b1111, 4'h2, 1'b0);
    to_edge(56);
    chk_slot("h1234_s3", 4'b0111, 4'h1, 1'b1);

    to_edge(61);
    chk("h0050_tick", {15'h0, frame_tick}, 16'h1);
    chk_slot("h0050_s0", 4'b1110, 4'h0, 1'b1);
    do_load(16'h0000, 4'b0000, 1'b1);
    to_edge(66);
    chk_slot("h0050_s1", 4'b1101, 4'h5, 1'b1);
    to_edge(71);
    chk("h0050_s2_an", {12'h0, an}, 16'h000f);
    chk("h0050_s2_dpn", {15'h0, dp_n}, 16'h1);
    to_edge(74);
    chk("h0050_s2_end", {12'h0, an}, 16'h000f);
    to_edge(76);
    chk("h0050_s3_an", {12'h0, an}, 16'h000f);
    to_edge(80);
    chk("h0050_pre_tick", {15'h0, frame_tick}, 16'h0);

    to_edge(81);
    chk("h0000_tick", {15'h0, frame_tick}, 16'h1);
    chk_slot("h0000_s0", 4'b1110, 4'h0, 1'b1);
    do_load(16'h5678, 4'b0000, 1'b0);
    to_edge(86);
    chk("h0000_s1_an", {12'h0, an}, 16'h000f);
    to_edge(91);
    chk("h0000_s2_an", {12'h0, an}, 16'h000f);
    to_edge(96);
    chk("h0000_s3_an", {12'h0, an}, 16'h000f);
    chk("b_pend", {15'h0, pending}, 16'h1);

    to_edge(100);
    do_load(16'h0AB0, 4'b0000, 1'b1);
    chk("ab_tick", {15'h0, frame_tick}, 16'h1);
    chk("ab_pend_stays", {15'h0, pending}, 16'h1);
    chk_slot("b_s0", 4'b1110, 4'h8, 1'b1);
    to_edge(116);
    chk_slot("b_s3", 4'b0111, 4'h5, 1'b1);
    to_edge(121);
    chk("a_pend_clr", {15'h0, pending}, 16'h0);
    chk_slot("a_s0", 4'b1110, 4'h0, 1'b1);
    to_edge(126);
    chk_slot("a_s1", 4'b1101, 4'hB, 1'b1);
    to_edge(131);
    chk_slot("a_s2", 4'b1011, 4'hA, 1'b1);
    to_edge(136);
    chk("a_s3_an", {12'h0, an}, 16'h000f);

    to_edge(141);
    do_load(16'h4321, 4'b1111, 1'b1);
    chk("pre_rst_pend", {15'h0, pending}, 16'h1);
    to_edge(153);
    chk("pre_rst_an", {12'h0, an}, 16'h000b);
    #2;
    reset = 1'b1;
    #1;
    chk("async_an", {12'h0, an}, 16'h000f);
    chk("async_pend", {15'h0, pending}, 16'h0);
    chk("async_bcd", {12'h0, bcd}, 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    e = 0;
    to_edge(1);
    chk_slot("rr_s0", 4'b1110, 4'h0, 1'b1);
    chk("rr_pend", {15'h0, pending}, 16'h0);
    to_edge(6);
    chk_slot("rr_s1", 4'b1101, 4'h0, 1'b1);
    to_edge(21);
    chk("rr_tick", {15'h0, frame_tick}, 16'h1);
    chk_slot("rr_f1_s0", 4'b1110, 4'h0, 1'b1);
    to_edge(36);
    chk_slot("rr_f1_s3", 4'b0111, 4'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
